unidad_logica: RTL and testbench
================================

# unidad_logica

Registered, parametrised logic unit: applies one of eight bitwise operations to two `ANCHO`-bit operands and presents the result through a one-entry output buffer with valid/ready handshakes on both sides. An internal accumulator register can replace operand `X`, so operations chain across transactions. It sits between a producer of operand pairs and any downstream consumer that may stall, and replaces single-bit fixed-gate logic in datapaths.

## Interface
- `ANCHO`, 8: operand/result width in bits (≥1).
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `en_valido`  in  1  input transaction offered.
- `en_listo`  out  1  block can accept input this cycle.
- `op`  in  3  operation select, sampled on acceptance.
- `acum`  in  1  1: operand A = accumulator `R`; 0: operand A = `X`.
- `limpiar`  in  1  synchronous clear of `R`.
- `X`  in  ANCHO  operand A (when `acum`=0).
- `Y`  in  ANCHO  operand B.
- `sal_valido`  out  1  `S` holds a result.
- `sal_listo`  in  1  consumer takes `S` this cycle.
- `S`  out  ANCHO  registered result.
- `cuenta`  out  8  accepted-transaction counter, wraps 255→0.
- `cero`, `paridad`  out  1 each  result flags (only with `UNIDAD_LOGICA_BANDERAS_EN`).

## Operation
- Acceptance: `acepta = en_valido & en_listo`; `en_listo = ~sal_valido | sal_listo` (combinational, no bubble under continuous flow).
- `op` encoding (A = operand A, B = `Y`): 000 A&B, 001 A|B, 010 ~A, 011 ~(A&B), 100 ~(A|B), 101 A^B, 110 ~(A^B), 111 A (pass).
- Output buffer states: VACIO (`sal_valido`=0), LLENO (`sal_valido`=1).
  - VACIO + acepta → LLENO, `S` loaded.
  - LLENO + sal_listo + acepta → LLENO, `S` reloaded with new result.
  - LLENO + sal_listo + ~acepta → VACIO, `S` holds last value.
  - LLENO + ~sal_listo → LLENO, `S`, flags stable; `en_listo`=0.
- Accumulator `R` (ANCHO bits): on acepta, `R` ← result regardless of `acum`.
- `limpiar`: `R` ← 0 next edge. With simultaneous acepta and `acum`=1, operand A uses 0 (clear applied first) and `R` ← that result. With simultaneous acepta and `acum`=0, `R` ← result (acceptance wins over clear).
- `limpiar` is independent of handshake; it works while output stalled.
- `cuenta` increments by 1 per acepta, modulo 256.
- Unused operand bits are ignored; no width extension, results are exactly ANCHO bits.

## Timing
- Latency: operands accepted at edge k appear on `S` with `sal_valido`=1 after edge k.
- Throughput: one result per cycle while `sal_listo`=1.
- Reset (async assert, sync release via `clk`): `sal_valido`=0, `S`=0, `R`=0, `cuenta`=0, `cero`=0, `paridad`=0; `en_listo`=1 immediately after reset while `sal_valido`=0.
- Reset mid-transaction: buffered result discarded, no output handshake completes.
- `en_listo` depends on `sal_listo` combinationally; no other combinational input→output paths.

## Configuration
- `UNIDAD_LOGICA_BANDERAS_EN` defined: ports `cero` (= result==0) and `paridad` (= XOR-reduce of result) exist, registered alongside `S`, same load/hold rules.
- Not defined: ports and flag registers absent; all other behaviour identical.

## Test plan
- Reset then `X`=8'hF0, `Y`=8'h3C, `op`=000, one-cycle valid, `sal_listo`=1 → next cycle `S`=8'h30, `sal_valido`=1, `cuenta`=1; flags `cero`=0, `paridad`=0.
- Sweep all 8 `op` codes with `X`=8'hA5, `Y`=8'h0F → `S` = 05, AF, 5A, FA, 50, AA, 55, A5 in order, back-to-back, one per cycle.
- Stall: result present, `sal_listo`=0 for 3 cycles with `en_valido`=1 → `en_listo`=0, `S` stable, `cuenta` unchanged; release → next operand accepted same cycle.
- Accumulate: `limpiar`=1 with accept `acum`=1, `op`=001, `Y`=8'h01; then `acum`=1, `op`=101, `Y`=8'hFF → `S`=8'h01 then 8'hFE; `R`=8'hFE.
- Wrap: 256 accepted transactions → `cuenta` returns to 0; `op`=000 with `Y`=0 → `cero`=1.
- Async `rst` asserted mid-stall → outputs immediately at reset values without waiting for `clk`.

Source files
------------

// File: rtl/unidad_logica_if.sv
// unidad_logica_if: bundle of handshake and data signals for unidad_logica.
//
// Handshakes (both sides): a transfer happens on a rising clk edge where
// valid and ready are both 1. The producer holds valid and its data until
// that edge. Ready may depend combinationally on the other side's ready,
// but never on valid.
//
// Signals
//   en_valido/en_listo  input side handshake (producer -> unit)
//   op, acum, limpiar   operation select, accumulator select, clear of R
//   X, Y                operands A and B
//   sal_valido/sal_listo output side handshake (unit -> consumer)
//   S                   registered result
//   cuenta              accepted-transaction counter (mod 256)
//   estado              debug view of the output buffer state (1 = full)
//   cero, paridad       result flags, present only with UNIDAD_LOGICA_BANDERAS_EN
//
// Modports: master = producer/consumer side, slave = the logic unit.
interface unidad_logica_if #(parameter int ANCHO = 8);
  logic             en_valido;
  logic             en_listo;
  logic [2:0]       op;
  logic             acum;
  logic             limpiar;
  logic [ANCHO-1:0] X;
  logic [ANCHO-1:0] Y;
  logic             sal_valido;
  logic             sal_listo;
  logic [ANCHO-1:0] S;
  logic [7:0]       cuenta;
  logic             estado;
`ifdef UNIDAD_LOGICA_BANDERAS_EN
  logic             cero;
  logic             paridad;
`endif

  modport master (
    output en_valido, op, acum, limpiar, X, Y, sal_listo,
    input  en_listo, sal_valido, S, cuenta, estado
`ifdef UNIDAD_LOGICA_BANDERAS_EN
    , input cero, paridad
`endif
  );

  modport slave (
    input  en_valido, op, acum, limpiar, X, Y, sal_listo,
    output en_listo, sal_valido, S, cuenta, estado
`ifdef UNIDAD_LOGICA_BANDERAS_EN
    , output cero, paridad
`endif
  );
endinterface

// File: rtl/unidad_logica.sv
// unidad_logica: registered ANCHO-bit logic unit with a one-entry output
// buffer and valid/ready handshakes on both sides.
//
// Ports
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset
//   bus  unidad_logica_if.slave (see interface header for the signal list)
//
// Optional feature: define UNIDAD_LOGICA_BANDERAS_EN to add the registered
// flags cero (result == 0) and paridad (XOR of result bits).
//
// op: 000 A&B, 001 A|B, 010 ~A, 011 ~(A&B), 100 ~(A|B), 101 A^B,
//     110 ~(A^B), 111 A. Operand A is the accumulator R when acum=1.
module unidad_logica #(
  parameter int ANCHO = 8
) (
  input  logic           clk,
  input  logic           rst,
  unidad_logica_if.slave bus
);

  typedef enum logic {
    VACIO = 1'b0,
    LLENO = 1'b1
  } estado_t;

  estado_t          estado_q;
  estado_t          estado_d;
  logic             sal_valido;
  logic             en_listo;
  logic             acepta;
  logic [ANCHO-1:0] operando_a;
  logic [ANCHO-1:0] resultado;
  logic [ANCHO-1:0] s_q;
  logic [ANCHO-1:0] r_q;
  logic [7:0]       cuenta_q;

  // Output buffer state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      estado_q <= VACIO;
    end else begin
      estado_q <= estado_d;
    end
  end

  // Next state: the buffer only empties when the consumer takes S and no
  // new result replaces it in the same cycle.
  always_comb begin
    estado_d = estado_q;
    case (estado_q)
      VACIO:   if (acepta) estado_d = LLENO;
      LLENO:   if (bus.sal_listo && !acepta) estado_d = VACIO;
      default: estado_d = VACIO;
    endcase
  end

  // Outputs of the buffer FSM. en_listo looks at sal_listo so a full
  // buffer being drained can be refilled in the same cycle.
  always_comb begin
    sal_valido = (estado_q == LLENO);
    en_listo   = !sal_valido || bus.sal_listo;
  end

  assign acepta = bus.en_valido && en_listo;

  // A clear arriving with an accumulate operation takes effect first, so
  // the operation sees R = 0.
  always_comb begin
    if (bus.acum) begin
      operando_a = bus.limpiar ? '0 : r_q;
    end else begin
      operando_a = bus.X;
    end
  end

  always_comb begin
    resultado = '0;
    case (bus.op)
      3'b000:  resultado = operando_a & bus.Y;
      3'b001:  resultado = operando_a | bus.Y;
      3'b010:  resultado = ~operando_a;
      3'b011:  resultado = ~(operando_a & bus.Y);
      3'b100:  resultado = ~(operando_a | bus.Y);
      3'b101:  resultado = operando_a ^ bus.Y;
      3'b110:  resultado = ~(operando_a ^ bus.Y);
      default: resultado = operando_a;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      r_q      <= '0;
      cuenta_q <= '0;
    end else begin
      if (acepta) begin
        s_q      <= resultado;
        cuenta_q <= cuenta_q + 8'd1;
      end
      // Acceptance wins over a plain clear; R always tracks the last result.
      if (acepta) begin
        r_q <= resultado;
      end else if (bus.limpiar) begin
        r_q <= '0;
      end
    end
  end

`ifdef UNIDAD_LOGICA_BANDERAS_EN
  logic cero_q;
  logic paridad_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cero_q    <= 1'b0;
      paridad_q <= 1'b0;
    end else if (acepta) begin
      cero_q    <= (resultado == '0);
      paridad_q <= ^resultado;
    end
  end

  assign bus.cero    = cero_q;
  assign bus.paridad = paridad_q;
`endif

  assign bus.en_listo   = en_listo;
  assign bus.sal_valido = sal_valido;
  assign bus.S          = s_q;
  assign bus.cuenta     = cuenta_q;
  assign bus.estado     = (estado_q == LLENO);

endmodule

// File: tb/tb_unidad_logica.sv
// Testbench for unidad_logica: table-driven directed vectors, hand-written
// corner sequences (stall, accumulate/clear, counter wrap, async reset) and
// a randomized phase, all checked against a per-bit truth-table model.
module tb_unidad_logica;

  localparam int ANCHO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  unidad_logica_if #(.ANCHO(ANCHO)) bus ();

  unidad_logica #(.ANCHO(ANCHO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- bookkeeping ----------------
  int n_total = 0;
  int n_ok    = 0;

  task automatic chk(input string nombre, input logic [31:0] actual,
                     input logic [31:0] esperado);
    n_total++;
    if (actual === esperado) n_ok++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nombre, actual, esperado, $time);
  endtask

  // ---------------- reference model ----------------
  // Each operation is a 2-input truth table indexed by {a_bit, b_bit}.
  function automatic logic [ANCHO-1:0] ref_logica(input logic [2:0] op,
                                                   input logic [ANCHO-1:0] a,
                                                   input logic [ANCHO-1:0] b);
    logic [3:0] tt [8];
    logic [ANCHO-1:0] r;
    tt[0] = 4'b1000; tt[1] = 4'b1110; tt[2] = 4'b0011; tt[3] = 4'b0111;
    tt[4] = 4'b0001; tt[5] = 4'b0110; tt[6] = 4'b1001; tt[7] = 4'b1100;
    for (int i = 0; i < ANCHO; i++) r[i] = tt[op][{a[i], b[i]}];
    return r;
  endfunction

  logic [ANCHO-1:0] exp_q [$];   // content of the one-entry output buffer
  logic [ANCHO-1:0] m_s;         // value S must show (held when empty)
  logic [ANCHO-1:0] m_r;
  int               m_cuenta;
  logic             m_cero, m_par;

  task automatic modelo_reset();
    exp_q.delete();
    m_s = '0; m_r = '0; m_cuenta = 0; m_cero = 1'b0; m_par = 1'b0;
  endtask

  task automatic chk_salidas(input string tag);
    chk({tag, "_sal_valido"}, 32'(bus.sal_valido), 32'(exp_q.size() != 0));
    chk({tag, "_S"}, 32'(bus.S), 32'(m_s));
    chk({tag, "_cuenta"}, 32'(bus.cuenta), 32'(m_cuenta));
`ifdef UNIDAD_LOGICA_BANDERAS_EN
    chk({tag, "_cero"}, 32'(bus.cero), 32'(m_cero));
    chk({tag, "_paridad"}, 32'(bus.paridad), 32'(m_par));
`endif
  endtask

  // ---------------- driver ----------------
  task automatic idle();
    bus.en_valido = 1'b0; bus.op = 3'd0; bus.acum = 1'b0; bus.limpiar = 1'b0;
    bus.X = '0; bus.Y = '0; bus.sal_listo = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    modelo_reset();
    @(posedge clk);
    #1;
    chk_salidas("reset");
    chk("reset_en_listo", 32'(bus.en_listo), 32'd1);
  endtask

  // One clock cycle: drive, check en_listo mid-cycle, advance, check outputs.
  task automatic paso(input logic ev, input logic [2:0] op, input logic acum,
                      input logic limp, input logic [ANCHO-1:0] x,
                      input logic [ANCHO-1:0] y, input logic sl,
                      output logic acepto);
    logic             listo;
    logic [ANCHO-1:0] a, res;
    bus.en_valido = ev; bus.op = op; bus.acum = acum; bus.limpiar = limp;
    bus.X = x; bus.Y = y; bus.sal_listo = sl;
    listo  = (exp_q.size() == 0) || sl;
    acepto = ev && listo;
    @(negedge clk);
    chk("en_listo", 32'(bus.en_listo), 32'(listo));
    @(posedge clk);
    if (acepto) begin
      a   = acum ? (limp ? '0 : m_r) : x;
      res = ref_logica(op, a, y);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      exp_q.push_back(res);
      m_s = res; m_r = res;
      m_cuenta = (m_cuenta + 1) % 256;
      m_cero = (res == 0);
      m_par  = ($countones(res) % 2) == 1;
    end else begin
      if (exp_q.size() != 0 && sl) void'(exp_q.pop_front());
      if (limp) m_r = '0;
    end
    #1;
    chk_salidas("paso");
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [2:0]       op;
    logic [ANCHO-1:0] x;
    logic [ANCHO-1:0] y;
    logic [ANCHO-1:0] exp_s;
    logic [7:0]       exp_cuenta;
  } vec_t;

  vec_t tabla [9];

  initial begin
    logic acc;
    int   aceptadas;
    int   ciclos;

    tabla[0] = '{3'd0, 8'hF0, 8'h3C, 8'h30, 8'd1};
    tabla[1] = '{3'd0, 8'hA5, 8'h0F, 8'h05, 8'd2};
    tabla[2] = '{3'd1, 8'hA5, 8'h0F, 8'hAF, 8'd3};
    tabla[3] = '{3'd2, 8'hA5, 8'h0F, 8'h5A, 8'd4};
    tabla[4] = '{3'd3, 8'hA5, 8'h0F, 8'hFA, 8'd5};
    tabla[5] = '{3'd4, 8'hA5, 8'h0F, 8'h50, 8'd6};
    tabla[6] = '{3'd5, 8'hA5, 8'h0F, 8'hAA, 8'd7};
    tabla[7] = '{3'd6, 8'hA5, 8'h0F, 8'h55, 8'd8};
    tabla[8] = '{3'd7, 8'hA5, 8'h0F, 8'hA5, 8'd9};

    do_reset();

    // First transaction and back-to-back sweep of all op codes
    for (int i = 0; i < 9; i++) begin
      paso(1'b1, tabla[i].op, 1'b0, 1'b0, tabla[i].x, tabla[i].y, 1'b1, acc);
      chk("tabla_S", 32'(bus.S), 32'(tabla[i].exp_s));
      chk("tabla_cuenta", 32'(bus.cuenta), 32'(tabla[i].exp_cuenta));
      chk("tabla_valido", 32'(bus.sal_valido), 32'd1);
`ifdef UNIDAD_LOGICA_BANDERAS_EN
      if (i == 0) begin
        chk("primero_cero", 32'(bus.cero), 32'd0);
        chk("primero_paridad", 32'(bus.paridad), 32'd0);
      end
`endif
    end

    // Stall: consumer not ready for 3 cycles, producer keeps offering
    for (int i = 0; i < 3; i++) begin
      paso(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h0F, 1'b0, acc);
      chk("stall_acepta", 32'(acc), 32'd0);
      chk("stall_S", 32'(bus.S), 32'hA5);
      chk("stall_cuenta", 32'(bus.cuenta), 32'd9);
    end
    paso(1'b1, 3'd0, 1'b0, 1'b0, 8'hFF, 8'h0F, 1'b1, acc);
    chk("liberar_S", 32'(bus.S), 32'h0F);
    chk("liberar_cuenta", 32'(bus.cuenta), 32'd10);

    // Accumulate: clear applied before an acum operation, then chain
    paso(1'b1, 3'd1, 1'b1, 1'b1, 8'h77, 8'h01, 1'b1, acc);
    chk("acum_or_S", 32'(bus.S), 32'h01);
    paso(1'b1, 3'd5, 1'b1, 1'b0, 8'h77, 8'hFF, 1'b1, acc);
    chk("acum_xor_S", 32'(bus.S), 32'hFE);
    paso(1'b1, 3'd7, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    chk("acum_R", 32'(bus.S), 32'hFE);

    // Clear while output stalled, then read R via pass-through
    paso(1'b0, 3'd0, 1'b0, 1'b1, 8'h00, 8'h00, 1'b0, acc);
    paso(1'b1, 3'd7, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1, acc);
    chk("limpiar_stall_R", 32'(bus.S), 32'h00);

    // Async reset in the middle of a stall, with no clock edge in between
    paso(1'b1, 3'd1, 1'b0, 1'b0, 8'h5A, 8'h81, 1'b0, acc);
    paso(1'b1, 3'd1, 1'b0, 1'b0, 8'h11, 8'h22, 1'b0, acc);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("rst_async_valido", 32'(bus.sal_valido), 32'd0);
    chk("rst_async_S", 32'(bus.S), 32'd0);
    chk("rst_async_cuenta", 32'(bus.cuenta), 32'd0);
    chk("rst_async_en_listo", 32'(bus.en_listo), 32'd1);

    // Randomized traffic until 256 accepts, checked against the model
    do_reset();
    aceptadas = 0;
    ciclos    = 0;
    while (aceptadas < 256 && ciclos < 4000) begin
      paso(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
           1'($urandom), ($urandom_range(0, 7) == 0), ANCHO'($urandom),
           ANCHO'($urandom), ($urandom_range(0, 3) != 0), acc);
      if (acc) aceptadas++;
      ciclos++;
    end
    chk("vuelta_presupuesto", 32'(aceptadas), 32'd256);
    chk("vuelta_cuenta", 32'(bus.cuenta), 32'd0);

    // Zero result sets cero
    paso(1'b1, 3'd0, 1'b0, 1'b0, 8'hC3, 8'h00, 1'b1, acc);
    chk("cero_S", 32'(bus.S), 32'd0);
`ifdef UNIDAD_LOGICA_BANDERAS_EN
    chk("cero_flag", 32'(bus.cero), 32'd1);
`endif

    $display("%0d/%0d checks passed", n_ok, n_total);
    $finish;
  end

endmodule
